// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: shared encodings for the HI/LO multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: MDOp opcode enum, FSM state enum, default cycle counts.
package hilo_mdu_pkg;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_ITERS_DEF  = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_NOP7  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DFIX = 2'b11
  } md_state_e;

endpackage

// File: rtl/hilo_mdu_div_core.sv
// div_core: iterative unsigned restoring divider, one quotient bit per cycle.
// Latency: DIV_ITERS cycles after start; done flags the cycle of the final iteration.
// Backpressure: none; start is honoured only when idle, abort cancels a running divide.
// Ports: clk/rst (sync, active high), start/abort, dividend/divisor in,
//        quotient/remainder/done out (results stable once done has been seen).
import hilo_mdu_pkg::*;

module div_core #(
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

  logic [31:0]      rem;
  logic [31:0]      quo;     // holds the dividend, shifted out as quotient bits shift in
  logic [31:0]      dvs;
  logic [CNT_W-1:0] cnt;
  logic             running;

  logic [32:0] rem_sh;
  logic [32:0] diff;

  // Bit 32 of diff is the borrow: clear means the trial subtraction fits.
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start && !running) begin
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_sh[31:0];
        quo <= {quo[30:0], 1'b0};
      end
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST) running <= 1'b0;
    end
  end

  assign done      = running && (cnt == LAST);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO register pair with multi-cycle MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Latency: MTHI/MTLO 1 edge; MULT(U) MUL_CYCLES busy cycles; DIV(U) DIV_ITERS+1 busy cycles.
// Backpressure: Busy high while occupied; Start is ignored unless idle, Flush cancels.
// Ports: clk, rst (sync, active high), Start/MDOp/A/B issue, Flush cancel,
//        RHLSel read select (1=HI), Busy, RHLOut (combinational HI/LO read).
import hilo_mdu_pkg::*;

module hilo_mdu #(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_ITERS  = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  input  logic        RHLSel,
  output logic        Busy,
  output logic [31:0] RHLOut
);

  localparam int MCNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [MCNT_W-1:0] MUL_LAST = MCNT_W'(MUL_CYCLES - 1);

  md_state_e         state, state_nxt;
  logic [31:0]       hi, lo;
  logic [31:0]       op_a, op_b;
  logic              mul_signed;
  logic              neg_q, neg_r;
  logic [MCNT_W-1:0] mul_cnt;
  logic              busy_q;

  logic        hi_we, lo_we;
  logic [31:0] hi_wd, lo_wd;
  logic        cap_mul, div_start;
  logic        is_signed;
  logic [31:0] mag_a, mag_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] div_q, div_r;
  logic        div_done;

  // Signed ops work on magnitudes; signs are reapplied in DFIX.
  assign is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
  assign mag_a     = (is_signed && A[31]) ? (32'd0 - A) : A;
  assign mag_b     = (is_signed && B[31]) ? (32'd0 - B) : B;

  // A 64-bit product of the extended operands is exact for both signednesses.
  assign ext_a = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
  assign ext_b = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
  assign prod  = ext_a * ext_b;

  div_core #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (Flush),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (div_q),
    .remainder(div_r),
    .done     (div_done)
  );

  always_comb begin
    state_nxt = state;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_wd     = '0;
    lo_wd     = '0;
    cap_mul   = 1'b0;
    div_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && !Flush) begin
          case (md_op_e'(MDOp))
            OP_MULT, OP_MULTU: begin
              cap_mul   = 1'b1;
              state_nxt = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero is a silent no-op.
              if (B != 32'd0) begin
                div_start = 1'b1;
                state_nxt = ST_DIV;
              end
            end
            OP_MTHI: begin
              hi_we = 1'b1;
              hi_wd = A;
            end
            OP_MTLO: begin
              lo_we = 1'b1;
              lo_wd = A;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (Flush) begin
          state_nxt = ST_IDLE;
        end else if (mul_cnt == MUL_LAST) begin
          hi_we     = 1'b1;
          lo_we     = 1'b1;
          hi_wd     = prod[63:32];
          lo_wd     = prod[31:0];
          state_nxt = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (Flush)         state_nxt = ST_IDLE;
        else if (div_done) state_nxt = ST_DFIX;
      end
      ST_DFIX: begin
        state_nxt = ST_IDLE;
        if (!Flush) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          lo_wd = neg_q ? (32'd0 - div_q) : div_q;
          hi_wd = neg_r ? (32'd0 - div_r) : div_r;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      mul_cnt    <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      if (hi_we) hi <= hi_wd;
      if (lo_we) lo <= lo_wd;
      if (cap_mul) begin
        op_a       <= A;
        op_b       <= B;
        mul_signed <= (MDOp == OP_MULT);
        mul_cnt    <= '0;
      end else if (state == ST_MUL) begin
        mul_cnt <= mul_cnt + MCNT_W'(1);
      end
      if (div_start) begin
        neg_q <= is_signed && (A[31] ^ B[31]);
        neg_r <= is_signed && A[31];
      end
    end
  end

  assign Busy   = busy_q;
  assign RHLOut = RHLSel ? hi : lo;

endmodule
